mcs4_rom_loader: RTL

//  Host-side ROM image loader that drives the i4001 debug write port (dbg_addr/dbg_wdata/dbg_wen).

---
 rtl/mcs4_rom_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mcs4_rom_loader.sv
// Host-side ROM image loader: streams host bytes into the i4001 debug write port
// and holds the MCS-4 system in reset until the image is in place.
package mcs4;
    typedef logic [3:0] char_t;
    typedef logic [7:0] byte_t;
endpackage

module mcs4_rom_loader #(
    parameter int unsigned WR_GAP      = 0,
    parameter int unsigned RELEASE_CYC = 4,
    parameter bit          BOOT_HOLD   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [11:0]       load_base,
    input  logic [12:0]       load_len,
    input  logic              load_abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output mcs4::char_t [2:0] dbg_addr,
    output mcs4::byte_t       dbg_wdata,
    output logic              dbg_wen,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_GAP     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;
    localparam logic [7:0] REL_LOAD = 8'(RELEASE_CYC - 1);

    // Handshake: a byte moves when s_valid && s_ready at a rising edge; s_ready is
    // high only in LOAD, and a host byte offered while s_ready=0 stays with the host.
    state_t      r_state;
    logic [11:0] r_addr;
    logic [12:0] r_remaining;
    logic [3:0]  r_gap_cnt;
    logic [7:0]  r_rel_cnt;

    logic w_xfer;
    logic w_len_ok;
    logic w_last;

    assign s_ready   = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
    assign w_xfer    = s_valid && s_ready;
    assign w_len_ok  = (load_len != 13'd0) && (load_len <= 13'd4096);
    assign w_last    = (r_remaining == 13'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
            r_rel_cnt   <= '0;
            dbg_addr    <= '0;
            dbg_wdata   <= '0;
            dbg_wen     <= 1'b0;
            cpu_hold    <= BOOT_HOLD;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            dbg_wen <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        if (w_len_ok) begin
                            r_addr      <= load_base;
                            r_remaining <= load_len;
                            cpu_hold    <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_start) err <= 1'b1;
                    if (w_xfer) begin
                        dbg_wen     <= 1'b1;
                        dbg_addr    <= r_addr;
                        dbg_wdata   <= s_data;
                        r_addr      <= r_addr + 12'd1;
                        r_remaining <= r_remaining - 13'd1;
                    end
                    // An abort still lets a byte accepted on the same edge be written.
                    if ((w_xfer && w_last) || load_abort) begin
                        r_rel_cnt <= REL_LOAD;
                        r_state   <= S_RELEASE;
                    end else if (w_xfer && (WR_GAP > 0)) begin
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (load_start) err <= 1'b1;
                    if (load_abort) begin
                        r_rel_cnt <= REL_LOAD;
                        r_state   <= S_RELEASE;
                    end else if (r_gap_cnt == 4'd0) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                S_RELEASE: begin
                    if (load_start) err <= 1'b1;
                    if (r_rel_cnt == 8'd0) begin
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_rel_cnt <= r_rel_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
